// File: rtl/mul_pipe.sv
// Pipelined WIDTH x WIDTH integer multiplier, signed/unsigned per op.
// Ports: clock, reset (sync, active high); in_valid/in_ready/in_a/in_b/
// in_signed accept side; out_valid/out_ready/out_prod emit side.
module mul_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod
);

  localparam int PW = 2 * WIDTH;
  // Reduction stages sit between the magnitude stage and the sign stage.
  localparam int RS = (STAGES >= 3) ? STAGES - 2 : 1;
  // Multiplier bits folded in by each reduction stage.
  localparam int CH = (WIDTH + RS - 1) / RS;

  typedef logic [WIDTH-1:0] op_t;
  typedef logic [PW-1:0]    prod_t;

  // Sum of shifted partial products for multiplier bits [lo, hi).
  function automatic prod_t pp(op_t a, op_t b, int lo, int hi);
    prod_t s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= lo && i < hi && b[i])
        s = s + (prod_t'(a) << i);
    end
    return s;
  endfunction

  function automatic prod_t fix(prod_t p, logic neg);
    return neg ? -p : p;
  endfunction

  logic  en;
  logic  a_neg;
  logic  b_neg;
  logic  sg_in;
  op_t   ma;
  op_t   mb;

  logic  v_q  [STAGES];
  logic  sg_q [STAGES];
  op_t   a_q  [STAGES];
  op_t   b_q  [STAGES];
  prod_t p_q  [STAGES];

  logic  v_d  [STAGES];
  logic  sg_d [STAGES];
  op_t   a_d  [STAGES];
  op_t   b_d  [STAGES];
  prod_t p_d  [STAGES];

  assign en        = !out_valid || out_ready;
  assign in_ready  = en && !reset;
  assign out_valid = v_q[STAGES-1];
  assign out_prod  = p_q[STAGES-1];

  // Two's complement negation of the most-negative value yields
  // 2^(WIDTH-1) when read unsigned, which is the exact magnitude.
  assign a_neg = in_signed && in_a[WIDTH-1];
  assign b_neg = in_signed && in_b[WIDTH-1];
  assign sg_in = a_neg ^ b_neg;
  assign ma    = a_neg ? -in_a : in_a;
  assign mb    = b_neg ? -in_b : in_b;

  always_comb begin
    v_d[0]  = in_valid && in_ready;
    sg_d[0] = sg_in;
    a_d[0]  = ma;
    b_d[0]  = mb;
    if (STAGES == 1)
      p_d[0] = fix(pp(ma, mb, 0, WIDTH), sg_in);
    else
      p_d[0] = '0;
    for (int s = 1; s < STAGES; s++) begin
      v_d[s]  = v_q[s-1];
      sg_d[s] = sg_q[s-1];
      a_d[s]  = a_q[s-1];
      b_d[s]  = b_q[s-1];
      if (s == STAGES - 1) begin
        if (STAGES == 2)
          p_d[s] = fix(pp(a_q[s-1], b_q[s-1], 0, WIDTH),
                       sg_q[s-1]);
        else
          p_d[s] = fix(p_q[s-1], sg_q[s-1]);
      end else begin
        p_d[s] = p_q[s-1]
               + pp(a_q[s-1], b_q[s-1],
                    (s - 1) * CH, s * CH);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s]  <= 1'b0;
        sg_q[s] <= 1'b0;
        a_q[s]  <= '0;
        b_q[s]  <= '0;
        p_q[s]  <= '0;
      end
    end else if (en) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s]  <= v_d[s];
        sg_q[s] <= sg_d[s];
        a_q[s]  <= a_d[s];
        b_q[s]  <= b_d[s];
        p_q[s]  <= p_d[s];
      end
    end
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Directed bench for mul_pipe: 8-bit/3-stage main instance, 16-bit/5-stage
// extremes instance and an exhaustive 4-bit/1-stage instance.
module tb_mul_pipe;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic        v8, r8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        v16, r16, s16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  logic        v4, r4, s4, ov4, or4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  mul_pipe #(.WIDTH(8), .STAGES(3)) dut8 (
    .clock(clock), .reset(reset),
    .in_valid(v8), .in_ready(r8),
    .in_a(a8), .in_b(b8), .in_signed(s8),
    .out_valid(ov8), .out_ready(or8), .out_prod(p8)
  );

  mul_pipe #(.WIDTH(16), .STAGES(5)) dut16 (
    .clock(clock), .reset(reset),
    .in_valid(v16), .in_ready(r16),
    .in_a(a16), .in_b(b16), .in_signed(s16),
    .out_valid(ov16), .out_ready(or16), .out_prod(p16)
  );

  mul_pipe #(.WIDTH(4), .STAGES(1)) dut4 (
    .clock(clock), .reset(reset),
    .in_valid(v4), .in_ready(r4),
    .in_a(a4), .in_b(b4), .in_signed(s4),
    .out_valid(ov4), .out_ready(or4), .out_prod(p4)
  );

  logic       bs [10] = '{0, 1, 0, 1, 1, 0, 1, 0, 1, 1};
  logic [7:0] ba [10] = '{8'h03, 8'hFE, 8'h10, 8'h7F, 8'h80,
                          8'h80, 8'h00, 8'hC8, 8'hF6, 8'h0C};
  logic [7:0] bb [10] = '{8'h05, 8'h03, 8'h10, 8'h7F, 8'h7F,
                          8'h02, 8'h80, 8'h64, 8'hF9, 8'hF0};
  logic [15:0] be [10] = '{16'h000F, 16'hFFFA, 16'h0100, 16'h3F01,
                           16'hC080, 16'h0100, 16'h0000, 16'h4E20,
                           16'h0046, 16'hFF40};

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic op8(logic [7:0] a, logic [7:0] b, logic s,
                     logic [15:0] exp, string tag);
    int lat;
    a8 = a; b8 = b; s8 = s; v8 = 1'b1; or8 = 1'b1;
    #1;
    chk({tag, "/ready"}, 64'(r8), 64'd1);
    tick();
    v8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "/latency"}, 64'(lat), 64'd2);
    chk({tag, "/prod"}, 64'(p8), 64'(exp));
    tick();
    chk({tag, "/drain"}, 64'(ov8), 64'd0);
  endtask

  task automatic op16(logic [15:0] a, logic [15:0] b, logic s,
                      logic [31:0] exp, string tag);
    int lat;
    a16 = a; b16 = b; s16 = s; v16 = 1'b1; or16 = 1'b1;
    tick();
    v16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "/latency"}, 64'(lat), 64'd4);
    chk({tag, "/prod"}, 64'(p16), 64'(exp));
    tick();
  endtask

  initial begin
    int sent, recv, cyc, x, y;
    logic acc, stall;
    logic [15:0] hp;
    logic [8:0] k;

    v8 = 0; s8 = 0; a8 = 0; b8 = 0; or8 = 1;
    v16 = 0; s16 = 0; a16 = 0; b16 = 0; or16 = 1;
    v4 = 0; s4 = 0; a4 = 0; b4 = 0; or4 = 1;

    tick();
    tick();
    chk("reset ready", 64'(r8), 64'd0);
    chk("reset valid", 64'(ov8), 64'd0);
    chk("reset prod", 64'(p8), 64'd0);
    reset = 1'b0;
    #1;
    chk("post reset ready", 64'(r8), 64'd1);

    op8(8'h80, 8'h80, 1'b1, 16'h4000, "s80x80");
    op8(8'h80, 8'h01, 1'b1, 16'hFF80, "s80x01");
    op8(8'hFF, 8'hFF, 1'b1, 16'h0001, "sFFxFF");
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "uFFxFF");

    // unsigned then signed on consecutive cycles
    or8 = 1; a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b0; v8 = 1'b1;
    tick();
    s8 = 1'b1;
    tick();
    v8 = 1'b0;
    tick();
    chk("b2b first valid", 64'(ov8), 64'd1);
    chk("b2b first prod", 64'(p8), 64'hFE01);
    tick();
    chk("b2b second valid", 64'(ov8), 64'd1);
    chk("b2b second prod", 64'(p8), 64'h0001);
    tick();
    chk("b2b drain", 64'(ov8), 64'd0);

    // backpressure stream
    sent = 0; recv = 0; cyc = 0;
    while (recv < 10 && cyc < 300) begin
      or8 = 1'($urandom_range(0, 1));
      v8 = (sent < 10);
      if (sent < 10) begin
        s8 = bs[sent]; a8 = ba[sent]; b8 = bb[sent];
      end
      #1;
      if (ov8 && !or8)
        chk("bp stall ready", 64'(r8), 64'd0);
      acc = v8 && r8;
      if (ov8 && or8) begin
        chk("bp prod", 64'(p8), 64'(be[recv]));
        recv++;
      end
      stall = ov8 && !or8;
      hp = p8;
      @(posedge clock);
      #1;
      if (acc) sent++;
      if (stall) begin
        chk("bp hold valid", 64'(ov8), 64'd1);
        chk("bp hold prod", 64'(p8), 64'(hp));
      end
      cyc++;
    end
    chk("bp received", 64'(recv), 64'd10);
    v8 = 0; or8 = 1;
    tick();
    tick();
    tick();
    chk("bp no extra", 64'(ov8), 64'd0);

    // reset with three ops in flight, none consumed
    or8 = 1'b0; v8 = 1'b1; s8 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      a8 = 8'(i); b8 = 8'h11;
      #1;
      chk("mid ready", 64'(r8), 64'd1);
      tick();
    end
    reset = 1'b1;
    a8 = 8'h22; b8 = 8'h22;
    #1;
    chk("mid reset ready", 64'(r8), 64'd0);
    tick();
    reset = 1'b0; v8 = 1'b0; or8 = 1'b1;
    chk("mid reset valid", 64'(ov8), 64'd0);
    chk("mid reset prod", 64'(p8), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid flushed", 64'(ov8), 64'd0);
    end
    op8(8'h05, 8'hFD, 1'b1, 16'hFFF1, "s5xm3");

    // 16-bit extremes through a 5-deep pipe
    op16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "w16 s8000x7FFF");
    op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16 uFFFFxFFFF");
    op16(16'h0000, 16'h8000, 1'b1, 32'h00000000, "w16 s0x8000");
    op16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "w16 s8000x8000");

    // exhaustive 4-bit, single stage, full throughput
    v4 = 1'b1; or4 = 1'b1;
    for (int i = 0; i < 512; i++) begin
      k = 9'(i);
      s4 = k[8]; a4 = k[7:4]; b4 = k[3:0];
      x = (s4 && a4[3]) ? int'(a4) - 16 : int'(a4);
      y = (s4 && b4[3]) ? int'(b4) - 16 : int'(b4);
      tick();
      chk("w4 exhaustive", 64'({ov4, p4}), 64'({1'b1, 8'(x * y)}));
    end
    v4 = 1'b0;
    tick();
    chk("w4 drain", 64'(ov4), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
